// File: rtl/qsm_dim_sequencer.sv
// QSPI sequencer for one DIM daisy-chain line: line RESET and register readout into RAM.
// Optional irq_o pulse on readout completion when QSM_SEQ_IRQ_EN is defined.
module qsm_dim_sequencer #(
  parameter int CLK_PER_US = 40,
  parameter int SCK_DIV    = 20,
  parameter int RESET_US   = 1000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ctrl_reset_i,
  input  logic        ctrl_trig_i,
  input  logic [3:0]  ctrl_last_reg_adr_i,
  input  logic [3:0]  ctrl_max_dim_no_i,
  input  logic [9:0]  ctrl_read_delay_i,
  output logic        stat_busy_o,
  output logic        stat_done_o,
  output logic        stat_err_many_o,
  output logic        stat_err_fb_o,
  output logic [3:0]  stat_dim_count_o,
  output logic        qspi_sck_o,
  input  logic        qspi_data_i,
  input  logic        qspi_fb_i,
  output logic        mem_we_o,
  output logic [7:0]  mem_addr_o,
  output logic [15:0] mem_data_o
`ifdef QSM_SEQ_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int UW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [UW-1:0] US_LAST  = UW'(CLK_PER_US - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);
  localparam logic [15:0]   RST_LAST = 16'(RESET_US - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_HOLD = 3'd1,
    SHIFT    = 3'd2,
    WORD_END = 3'd3,
    DELAY    = 3'd4
  } state_t;

  state_t        state;
  logic          data_s1, data_s2, fb_s1, fb_s2;
  logic [UW-1:0] us_cnt;
  logic [15:0]   tick_cnt;
  logic [DW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic [15:0]   shreg;
  logic [3:0]    reg_idx, dev_idx;
  logic [3:0]    last_reg, max_dim;
  logic [9:0]    read_delay;
  logic          us_tick;
  logic [4:0]    count;

  assign us_tick = (us_cnt == US_LAST);
  assign count   = {1'b0, dev_idx} + 5'd1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_s1 <= 1'b0;
      data_s2 <= 1'b0;
      fb_s1   <= 1'b0;
      fb_s2   <= 1'b0;
    end else begin
      data_s1 <= qspi_data_i;
      data_s2 <= data_s1;
      fb_s1   <= qspi_fb_i;
      fb_s2   <= fb_s1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state            <= IDLE;
      us_cnt           <= '0;
      tick_cnt         <= 16'd0;
      div_cnt          <= '0;
      bit_cnt          <= 5'd0;
      shreg            <= 16'd0;
      reg_idx          <= 4'd0;
      dev_idx          <= 4'd0;
      last_reg         <= 4'd0;
      max_dim          <= 4'd0;
      read_delay       <= 10'd0;
      stat_busy_o      <= 1'b0;
      stat_done_o      <= 1'b0;
      stat_err_many_o  <= 1'b0;
      stat_err_fb_o    <= 1'b0;
      stat_dim_count_o <= 4'd0;
      qspi_sck_o       <= 1'b1;
      mem_we_o         <= 1'b0;
      mem_addr_o       <= 8'd0;
      mem_data_o       <= 16'd0;
    end else begin
      us_cnt   <= us_tick ? '0 : us_cnt + 1'b1;
      mem_we_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_reset_i) begin
            state       <= RST_HOLD;
            qspi_sck_o  <= 1'b0;
            stat_busy_o <= 1'b1;
            us_cnt      <= '0;
            tick_cnt    <= 16'd0;
          end else if (ctrl_trig_i) begin
            last_reg        <= ctrl_last_reg_adr_i;
            max_dim         <= ctrl_max_dim_no_i;
            read_delay      <= ctrl_read_delay_i;
            stat_done_o     <= 1'b0;
            stat_err_many_o <= 1'b0;
            stat_err_fb_o   <= 1'b0;
            stat_busy_o     <= 1'b1;
            reg_idx         <= 4'd0;
            dev_idx         <= 4'd0;
            div_cnt         <= DIV_LAST;
            bit_cnt         <= 5'h1F;
            state           <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        RST_HOLD: begin
          if (us_tick) begin
            if (tick_cnt == RST_LAST) begin
              qspi_sck_o  <= 1'b1;
              stat_busy_o <= 1'b0;
              state       <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 16'd1;
            end
          end
        end
        // Entry preloads the end of a high phase with bit_cnt=-1 so the first cycle drops sck.
        SHIFT: begin
          if (max_dim == 4'd0) begin
            stat_err_many_o <= 1'b1;
            stat_done_o     <= 1'b1;
            stat_busy_o     <= 1'b0;
            state           <= IDLE;
          end else if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!qspi_sck_o) begin
              qspi_sck_o <= 1'b1;
              shreg      <= {shreg[14:0], data_s2};
            end else if (bit_cnt == 5'd15) begin
              mem_we_o   <= 1'b1;
              mem_addr_o <= {reg_idx, dev_idx};
              mem_data_o <= shreg;
              state      <= WORD_END;
            end else begin
              qspi_sck_o <= 1'b0;
              bit_cnt    <= bit_cnt + 5'd1;
            end
          end
        end
        WORD_END: begin
          if (fb_s2) begin
            if (reg_idx == 4'd0) begin
              stat_dim_count_o <= count[3:0];
            end else if (count[3:0] != stat_dim_count_o) begin
              stat_err_fb_o <= 1'b1;
            end else begin
              stat_err_fb_o <= stat_err_fb_o;
            end
            if (reg_idx == last_reg) begin
              stat_done_o <= 1'b1;
              stat_busy_o <= 1'b0;
              state       <= IDLE;
            end else begin
              reg_idx  <= reg_idx + 4'd1;
              dev_idx  <= 4'd0;
              us_cnt   <= '0;
              tick_cnt <= 16'd0;
              state    <= DELAY;
            end
          end else if (count == {1'b0, max_dim}) begin
            stat_err_many_o <= 1'b1;
            stat_done_o     <= 1'b1;
            stat_busy_o     <= 1'b0;
            state           <= IDLE;
          end else begin
            dev_idx <= dev_idx + 4'd1;
            div_cnt <= DIV_LAST;
            bit_cnt <= 5'h1F;
            state   <= SHIFT;
          end
        end
        DELAY: begin
          if (read_delay == 10'd0 ||
              (us_tick && tick_cnt == (16'(read_delay) - 16'd1))) begin
            div_cnt <= DIV_LAST;
            bit_cnt <= 5'h1F;
            state   <= SHIFT;
          end else if (us_tick) begin
            tick_cnt <= tick_cnt + 16'd1;
          end else begin
            tick_cnt <= tick_cnt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef QSM_SEQ_IRQ_EN
  logic done_q;

  // Edge detect on done; pulses one cycle after done rises.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      done_q <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      done_q <= stat_done_o;
      irq_o  <= stat_done_o & ~done_q;
    end
  end
`endif

endmodule
